// File: rtl/lisnoc_mp_packet_arbiter_if.sv
// Handshake bundle between the packet buffers, the arbiter and the NoC link.
// Senders drive in_*, the arbiter answers with in_ready and the out_* side.
interface lisnoc_mp_packet_arbiter_if #(
    parameter int noc_data_width = 32,
    parameter int noc_type_width = 2,
    parameter int ports = 4
) ();
    localparam int flit_width = noc_data_width + noc_type_width;
    localparam int port_width = (ports > 1) ? $clog2(ports) : 1;

    logic [ports*flit_width-1:0] in_flit;
    logic [ports-1:0]            in_valid;
    logic [ports-1:0]            in_ready;
    logic [flit_width-1:0]       out_flit;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    logic [port_width-1:0]       grant_port;

    modport master (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_flit, out_valid, busy, grant_port
    );

    modport slave (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_flit, out_valid, busy, grant_port
    );
endinterface

// File: rtl/lisnoc_mp_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC link between senders.
// A grant lasts from selection until the LAST or SINGLE flit is transferred.
module lisnoc_mp_packet_arbiter #(
    parameter int noc_data_width = 32,
    parameter int noc_type_width = 2,
    parameter int ports = 4
) (
    input logic clk,
    input logic rst,
    lisnoc_mp_packet_arbiter_if.slave bus
);
    localparam int flit_width = noc_data_width + noc_type_width;
    localparam int port_width = (ports > 1) ? $clog2(ports) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic [port_width-1:0] grant, grant_nxt;
    logic [port_width-1:0] ptr, ptr_nxt;
    logic [port_width-1:0] pick;
    logic                  found;
    logic [flit_width-1:0] sel_flit;
    logic                  sel_valid;
    logic                  sel_last;

    always_comb begin
        sel_flit  = bus.in_flit[flit_width-1:0];
        sel_valid = bus.in_valid[0];
        for (int i = 0; i < ports; i++) begin
            if (grant == port_width'(i)) begin
                sel_flit  = bus.in_flit[i*flit_width +: flit_width];
                sel_valid = bus.in_valid[i];
            end
        end
    end

    // LAST (10) and SINGLE (11) both have the upper type bit set
    assign sel_last = sel_flit[noc_data_width+1];

    // first valid port at or after ptr, searched cyclically
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < ports; k++) begin
            for (int j = 0; j < ports; j++) begin
                if (!found && ptr == port_width'(j)
                    && bus.in_valid[(j + k) % ports]) begin
                    found = 1'b1;
                    pick  = port_width'((j + k) % ports);
                end
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        ptr_nxt        = ptr;
        bus.out_flit   = sel_flit;
        bus.out_valid  = 1'b0;
        bus.in_ready   = '0;
        bus.busy       = 1'b0;
        bus.grant_port = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                bus.out_valid  = sel_valid;
                bus.busy       = 1'b1;
                bus.grant_port = grant;
                for (int i = 0; i < ports; i++) begin
                    if (grant == port_width'(i)) begin
                        bus.in_ready[i] = bus.out_ready;
                    end
                end
                if (sel_valid && bus.out_ready && sel_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = port_width'((int'(grant) + 1) % ports);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end
endmodule
